// File: rtl/rand_pkg.sv
// rtl/rand_pkg.sv - taus88 constants, default/minimum seeds and scheduler state type
package rand_pkg;

    localparam logic [31:0] SEED0_DEF = 32'hDEADBEE0;
    localparam logic [31:0] SEED1_DEF = 32'hCAFEBAB0;
    localparam logic [31:0] SEED2_DEF = 32'hACDC0000;
    localparam logic [95:0] SEEDS_DEF = {SEED2_DEF, SEED1_DEF, SEED0_DEF};

    // Components whose seed falls below these lock into a short cycle.
    localparam logic [31:0] SEED0_MIN = 32'd2;
    localparam logic [31:0] SEED1_MIN = 32'd8;
    localparam logic [31:0] SEED2_MIN = 32'd16;

    localparam int          C0_Q    = 13;
    localparam int          C0_S1   = 19;
    localparam int          C0_S2   = 12;
    localparam logic [31:0] C0_MASK = 32'hFFFFFFFE;
    localparam int          C1_Q    = 2;
    localparam int          C1_S1   = 25;
    localparam int          C1_S2   = 4;
    localparam logic [31:0] C1_MASK = 32'hFFFFFFF8;
    localparam int          C2_Q    = 3;
    localparam int          C2_S1   = 11;
    localparam int          C2_S2   = 17;
    localparam logic [31:0] C2_MASK = 32'hFFFFFFF0;

    typedef enum logic {
        ST_WARM = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_t;

    function automatic logic [31:0] taus_comp(input logic [31:0] s, input int q,
                                              input int sa, input int sb,
                                              input logic [31:0] mask);
        return (((s << q) ^ s) >> sa) ^ ((s & mask) << sb);
    endfunction

    function automatic logic [95:0] seed_sanitize(input logic [95:0] sd);
        logic [31:0] s0;
        logic [31:0] s1;
        logic [31:0] s2;
        s0 = (sd[31:0]  < SEED0_MIN) ? SEED0_DEF : sd[31:0];
        s1 = (sd[63:32] < SEED1_MIN) ? SEED1_DEF : sd[63:32];
        s2 = (sd[95:64] < SEED2_MIN) ? SEED2_DEF : sd[95:64];
        return {s2, s1, s0};
    endfunction

endpackage

// File: rtl/taus_step.sv
// rtl/taus_step.sv - one combinational taus88 step: next seeds and combined output word
module taus_step
    import rand_pkg::*;
(
    input  logic [95:0] seeds,
    output logic [95:0] next_seeds,
    output logic [31:0] word
);

    logic [31:0] n0;
    logic [31:0] n1;
    logic [31:0] n2;

    assign n0 = taus_comp(seeds[31:0],  C0_Q, C0_S1, C0_S2, C0_MASK);
    assign n1 = taus_comp(seeds[63:32], C1_Q, C1_S1, C1_S2, C1_MASK);
    assign n2 = taus_comp(seeds[95:64], C2_Q, C2_S1, C2_S2, C2_MASK);

    assign next_seeds = {n2, n1, n0};
    assign word       = n0 ^ n1 ^ n2;

endmodule

// File: rtl/rand_scheduler.sv
// rtl/rand_scheduler.sv - round-robin sharing of one taus88 generator with warm-up sequencing
// Build option: RAND_RESEED_EN enables run-time reseeding through seed_load/seed_data.
module rand_scheduler
    import rand_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int WARMUP = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [31:0]      rand_out,
    output logic             rand_valid,
    output logic             warming,
    input  logic             seed_load,
    input  logic [95:0]      seed_data,
    output logic             seed_ack
);

    localparam int         PW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PW-1:0] LAST_IDX  = PW'(N_REQ - 1);
    localparam logic [7:0]    WARM_LAST = 8'(WARMUP - 1);

    sched_state_t     state_q, state_d;
    logic [95:0]      seeds_q, seeds_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [31:0]      rand_q, rand_d;
    logic             ack_q, ack_d;

    logic [95:0]      step_seeds;
    logic [31:0]      step_word;
    logic             reseed_go;
    logic [95:0]      reseed_val;
    logic             win_valid;
    logic [PW-1:0]    win_idx;
    int               arb_sum;

    taus_step u_taus_step (
        .seeds      (seeds_q),
        .next_seeds (step_seeds),
        .word       (step_word)
    );

`ifdef RAND_RESEED_EN
    assign reseed_go  = seed_load;
    assign reseed_val = seed_sanitize(seed_data);
`else
    logic unused_seed;
    assign reseed_go   = 1'b0;
    assign reseed_val  = SEEDS_DEF;
    assign unused_seed = ^{seed_load, seed_data};
`endif

    // First requester at or after the pointer, wrapping.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        arb_sum   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            arb_sum = int'(ptr_q) + i;
            if (arb_sum >= N_REQ) begin
                arb_sum = arb_sum - N_REQ;
            end
            if (!win_valid && req[arb_sum[PW-1:0]]) begin
                win_valid = 1'b1;
                win_idx   = arb_sum[PW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        seeds_d = seeds_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        rand_d  = rand_q;
        ack_d   = 1'b0;
        if (reseed_go) begin
            seeds_d = reseed_val;
            cnt_d   = '0;
            state_d = ST_WARM;
            ack_d   = 1'b1;
        end else begin
            case (state_q)
                ST_WARM: begin
                    seeds_d = step_seeds;
                    cnt_d   = cnt_q + 8'd1;
                    if (cnt_q == WARM_LAST) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // The generator only advances when a word is consumed.
                    if (win_valid) begin
                        seeds_d        = step_seeds;
                        rand_d         = step_word;
                        gnt_d[win_idx] = 1'b1;
                        ptr_d          = (win_idx == LAST_IDX) ? '0 : win_idx + PW'(1);
                    end
                end
                default: state_d = ST_WARM;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_WARM;
            seeds_q <= SEEDS_DEF;
            cnt_q   <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            rand_q  <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            seeds_q <= seeds_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            rand_q  <= rand_d;
            ack_q   <= ack_d;
        end
    end

    assign gnt        = gnt_q;
    assign rand_out   = rand_q;
    assign rand_valid = |gnt_q;
    assign warming    = (state_q == ST_WARM);
    assign seed_ack   = ack_q;

endmodule
